// File: rtl/amba3_apb_slave_mem_pkg.sv
// Shared types and helpers for the AMBA 3 APB completer memory.
package pkg_amba3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } amba3_apb_slv_state_e;

    localparam int unsigned AMBA3_APB_CNT_W = 4;

    // Byte-offset bits below the word index: log2(DATA_SIZE/8).
    function automatic int unsigned amba3_apb_lsb(input int unsigned data_size);
        return $clog2(data_size / 8);
    endfunction

endpackage

// File: rtl/amba3_apb_slave_mem_ram.sv
// Single-port synchronous word array with a registered read port; contents are not reset.
module amba3_apb_ram #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [IDX_W-1:0]     addr,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/amba3_apb_slave_mem.sv
// AMBA 3 APB completer memory with WAIT_STATES PREADY-low cycles per transfer.
// Define AMBA3_APB_SLVERR_EN to flag out-of-range accesses on pslverr.
module amba3_apb_slave_mem
    import pkg_amba3::*;
#(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int unsigned LSB   = amba3_apb_lsb(DATA_SIZE);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(DATA_SIZE / 8);
    localparam logic [AMBA3_APB_CNT_W-1:0] WS = AMBA3_APB_CNT_W'(WAIT_STATES);

`ifdef AMBA3_APB_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    amba3_apb_slv_state_e       state_q;
    logic [AMBA3_APB_CNT_W-1:0] cnt_q;
    logic                       wr_q;
    logic                       oor_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       rd_zero_q;
    logic                       pready_q;
    logic                       pslverr_q;

    logic                       setup;
    logic                       in_range;
    logic [IDX_W-1:0]           idx_in;
    logic                       ram_we;
    logic                       ram_re;
    logic [IDX_W-1:0]           ram_addr;
    logic [DATA_SIZE-1:0]       ram_rdata;

    always_comb begin
        setup    = (state_q == IDLE) && psel && !penable;
        in_range = 64'(paddr) < MEM_BYTES;
        idx_in   = paddr[LSB +: IDX_W];
        ram_re   = setup && !pwrite && in_range;
        ram_we   = (state_q == READY) && psel && penable && wr_q && !oor_q;
        // Reads only happen in IDLE and writes only in READY, so one port suffices.
        ram_addr = (state_q == IDLE) ? idx_in : idx_q;
    end

    amba3_apb_ram #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk   (pclk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (pwdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            oor_q     <= 1'b0;
            idx_q     <= '0;
            rd_zero_q <= 1'b1;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (setup) begin
                        wr_q  <= pwrite;
                        oor_q <= !in_range;
                        idx_q <= idx_in;
                        cnt_q <= WS;
                        // prdata only changes on reads, or on error-flagged accesses.
                        if (!pwrite || (SLVERR_EN && !in_range)) begin
                            rd_zero_q <= !in_range;
                        end
                        if (WS == '0) begin
                            state_q   <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= SLVERR_EN && !in_range;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q <= AMBA3_APB_CNT_W'(1)) begin
                        state_q   <= READY;
                        cnt_q     <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= SLVERR_EN && oor_q;
                    end else begin
                        cnt_q <= cnt_q - AMBA3_APB_CNT_W'(1);
                    end
                end
                READY: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prdata  = rd_zero_q ? '0 : ram_rdata;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_amba3_apb_slave_mem.sv
// Directed scoreboard bench for amba3_apb_slave_mem at WAIT_STATES of 0, 3 and 5.
module tb_amba3_apb_slave_mem;

    logic        pclk     = 1'b0;
    logic        preset_n = 1'b0;
    logic        penable  = 1'b0;
    logic        pwrite   = 1'b0;
    logic [2:0]  psel     = '0;
    logic [31:0] paddr    = '0;
    logic [31:0] pwdata   = '0;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

`ifdef AMBA3_APB_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    always #5 pclk = ~pclk;

    amba3_apb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]),
        .pready(pready_v[0]), .pslverr(pslverr_v[0])
    );

    amba3_apb_slave_mem #(.WAIT_STATES(3)) u_dut1 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]),
        .pready(pready_v[1]), .pslverr(pslverr_v[1])
    );

    amba3_apb_slave_mem #(.WAIT_STATES(5)) u_dut2 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]),
        .pready(pready_v[2]), .pslverr(pslverr_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the completing edge so
    // a following call issues its SETUP back-to-back. For reads, data is the expected word.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_wait, input bit exp_err);
        int waits = 0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        if (!wr) exp_q.push_back(data);
        @(negedge pclk);
        check($sformatf("setup_pready_d%0d_%h", d, addr), 32'(pready_v[d]), 32'(0));
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        while (pready_v[d] !== 1'b1 && waits <= 40) begin
            waits++;
            @(negedge pclk);
        end
        check($sformatf("wait_cycles_d%0d_%h", d, addr), 32'(waits), 32'(exp_wait));
        check($sformatf("pslverr_d%0d_%h", d, addr), 32'(pslverr_v[d]), 32'(exp_err));
        if (!wr) check($sformatf("rdata_d%0d_%h", d, addr), prdata_v[d], exp_q.pop_front());
        @(posedge pclk);
        #1;
        psel[d] = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        // Reset held for 50 cycles
        preset_n = 1'b0;
        repeat (50) begin
            @(negedge pclk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("reset_pready_d%0d", i), 32'(pready_v[i]), 32'(0));
                check($sformatf("reset_pslverr_d%0d", i), 32'(pslverr_v[i]), 32'(0));
                check($sformatf("reset_prdata_d%0d", i), prdata_v[i], 32'(0));
            end
        end
        preset_n = 1'b1;
        @(posedge pclk);
        #1;

        // Basic back-to-back write/read, no wait states
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);

        // Three wait states, top word
        xfer(1, 1'b1, 32'h3FC, 32'h12345678, 3, 1'b0);
        xfer(1, 1'b0, 32'h3FC, 32'h12345678, 3, 1'b0);

        // Unaligned write lands on the aligned word
        xfer(0, 1'b1, 32'h22, 32'hA5A5A5A5, 0, 1'b0);
        xfer(0, 1'b0, 32'h20, 32'hA5A5A5A5, 0, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);

        // Out-of-range: 0x400 aliases word 0 by index but must not touch it
        xfer(0, 1'b1, 32'h0, 32'h0BADF00D, 0, 1'b0);
        xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 0, SLV);
        check("oor_write_prdata", prdata_v[0], SLV ? 32'h0 : 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h400, 32'h0, 0, SLV);
        xfer(0, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b0);

        // prdata holds across a write
        xfer(0, 1'b1, 32'h10, 32'h0, 0, 1'b0);
        check("prdata_hold", prdata_v[0], 32'h0BADF00D);
        xfer(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        xfer(0, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b0);

        // Five wait states: baseline value at 0x8
        xfer(2, 1'b1, 32'h8, 32'h11111111, 5, 1'b0);
        xfer(2, 1'b0, 32'h8, 32'h11111111, 5, 1'b0);

        // Reset in the 2nd ACCESS cycle of a write
        psel[2] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'h22222222;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #2 preset_n = 1'b0;
        #1;
        check("midrst_pready_d2", 32'(pready_v[2]), 32'(0));
        check("midrst_prdata_d0", prdata_v[0], 32'h0);
        check("midrst_prdata_d1", prdata_v[1], 32'h0);
        check("midrst_prdata_d2", prdata_v[2], 32'h0);
        @(negedge pclk);
        preset_n = 1'b1;
        repeat (8) begin
            @(negedge pclk);
            check("post_rst_pready_d2", 32'(pready_v[2]), 32'(0));
        end
        @(posedge pclk);
        #1;
        psel[2] = 1'b0;
        penable = 1'b0;
        xfer(2, 1'b0, 32'h8, 32'h11111111, 5, 1'b0);

        // psel dropped while in WAIT aborts the write
        psel[2] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'h33333333;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1;
        psel[2] = 1'b0;
        penable = 1'b0;
        repeat (10) begin
            @(negedge pclk);
            check("abort_pready_d2", 32'(pready_v[2]), 32'(0));
        end
        @(posedge pclk);
        #1;
        xfer(2, 1'b0, 32'h8, 32'h11111111, 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/amba3_apb_slave_mem.md
# amba3_apb_slave_mem

Synthesizable AMBA 3 APB completer: a word-addressed memory that sits directly downstream of the APB master VIP on the shared `amba3_apb_if` bus. It is the block the master drives in bench runs. It accepts read and write transfers and inserts a parameterised number of wait states through PREADY. Out-of-range accesses can optionally be flagged on PSLVERR.

## Interface
- `ADDR_SIZE`, 32, PADDR width in bits
- `DATA_SIZE`, 32, PWDATA/PRDATA width in bits; must be 8, 16, 32 or 64
- `DEPTH`, 256, number of DATA_SIZE-bit words; power of two, at least 2
- `WAIT_STATES`, 0, number of PREADY-low ACCESS cycles per transfer, range 0..15
- `pclk`, in, 1, bus clock; everything is sampled on its rising edge
- `preset_n`, in, 1, reset; asynchronous assert, active-low
- `psel`, in, 1, slave select
- `penable`, in, 1, ACCESS phase indicator
- `pwrite`, in, 1, 1 = write, 0 = read
- `paddr`, in, ADDR_SIZE, byte address
- `pwdata`, in, DATA_SIZE, write data
- `prdata`, out, DATA_SIZE, read data; valid while `pready`=1 on a read
- `pready`, out, 1, transfer completion
- `pslverr`, out, 1, error response; valid only while `pready`=1

## Operation
- Address decode:
  - word index = `paddr[LSB +: IDX_W]`, with LSB = log2(DATA_SIZE/8) and IDX_W = log2(DEPTH).
  - `paddr[LSB-1:0]` is ignored; unaligned accesses are treated as aligned.
  - In range means `paddr` < DEPTH*DATA_SIZE/8.
- FSM states:
  - IDLE: `pready`=0. On `psel`=1 and `penable`=0 (SETUP), the block latches `pwrite` and the index, loads the wait counter with WAIT_STATES, and captures the read word into `prdata` if the access is a read in range. It then moves to READY if WAIT_STATES=0, otherwise to WAIT.
  - WAIT: `pready`=0; the counter decrements each cycle. When the counter reaches 1, the FSM moves to READY.
  - READY: `pready`=1. At the completing edge (`psel`=`penable`=1), a write in range stores `pwdata`. The FSM then always returns to IDLE, which accepts the next SETUP on the following cycle (back-to-back transfers).
- Master protocol violation: if `psel`=0 in WAIT or READY, the transfer is aborted. The FSM returns to IDLE, the memory is not written, and `pready` goes to 0.
- Read data outside a read transfer: `prdata` holds its last value; it is not zeroed.
- Out-of-range reads return 0.
- Read-after-write: a write that commits at edge N is visible to a SETUP sampled at edge N+1.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, FSM=IDLE, counter=0. Memory contents are not reset.
- Reset asserted mid-transfer: outputs take their reset values immediately and an in-flight write is dropped.
- Transfer length is 2+WAIT_STATES cycles (SETUP plus ACCESS cycles). `pready` rises in the (WAIT_STATES+1)th ACCESS cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `AMBA3_APB_SLVERR_EN` defined:
  - An out-of-range access completes with `pslverr`=1 alongside `pready`=1, with no memory write and `prdata`=0.
  - `pslverr`=0 in every other cycle.
- Macro undefined:
  - `pslverr` is tied to 0.
  - Out-of-range accesses complete normally: writes are discarded and reads return 0.

## Structure
- The following go into the shared package `pkg_amba3`:
  - FSM state enum `amba3_apb_slv_state_e` (IDLE, WAIT, READY).
  - Localparam helper function `amba3_apb_lsb(DATA_SIZE)`.
- One sub-module, `amba3_apb_ram`: single-port synchronous array with a DEPTH×DATA_SIZE write port and a registered read port. It has no reset.
- FSM, decode and counter logic live in the top module.

## Test plan
- Reset check: WAIT_STATES=0. Assert `preset_n`=0 for 50 cycles → `pready`=0, `pslverr`=0, `prdata`=0 throughout.
- Basic write/read: WAIT_STATES=0. Write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → each transfer takes 2 cycles and the read returns 0xDEADBEEF.
- Wait states: WAIT_STATES=3. Write 0x1234_5678 to 0x3FC, then read it → `pready` is low for 3 ACCESS cycles each time, and the read returns 0x1234_5678 (index 255).
- Unaligned address: write 0xA5A5A5A5 to 0x22, then read 0x20 → read returns 0xA5A5A5A5.
- Out-of-range access: write then read 0x400 with `AMBA3_APB_SLVERR_EN` defined → `pslverr`=1 with `pready`, read returns 0, and word 0 is unchanged. Repeat with the macro undefined → `pslverr`=0.
- Reset and abort mid-transfer: WAIT_STATES=5.
  - Drop `preset_n` in the 2nd ACCESS cycle of a write to 0x8 → `pready`=0 at once, and a later read of 0x8 does not return the written data.
  - Drop `psel` in WAIT → the FSM returns to IDLE with no write.
